mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Parametrised N-port arbiter between cache memory-side ports and the single `axi_interface` cache port, replacing the fixed two-way `sel_i` mux in the CPU top. Each requester (I-cache ways, D-cache, future uncached/prefetch ports) raises a request; the arbiter locks one grant per transaction, steers its address/control/store data to `axi_interface`, and returns `mem_ready` only to the granted port. Load data (`mem_data`) is broadcast to all ports outside this block.

## Interface
- `NUM_PORTS`, 2: number of requesters, legal 2..8.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: store data width; `DATA_W/8` strobe bits.
- `GW`, derived `$clog2(NUM_PORTS)`: grant index width.

- `aclk` in 1: clock.
- `aresetn` in 1: asynchronous active-low reset.
- `req_access` in NUM_PORTS: per-port request; held until the matching `req_ready`.
- `req_write` in NUM_PORTS: 1 = store, 0 = load.
- `req_a` in NUM_PORTS*ADDR_W: per-port address, port i at bits [i*ADDR_W +: ADDR_W].
- `req_size` in NUM_PORTS*2: per-port size (00 byte, 01 half, 10 word).
- `req_sel` in NUM_PORTS*DATA_W/8: per-port byte strobes.
- `req_st_data` in NUM_PORTS*DATA_W: per-port store data.
- `req_ready` out NUM_PORTS: one-hot completion pulse to the granted port.
- `mem_access`, `mem_write` out 1: to `axi_interface`.
- `mem_a` out ADDR_W; `mem_size` out 2; `mem_sel` out DATA_W/8; `mem_st_data` out DATA_W.
- `mem_ready` in 1: transaction complete from `axi_interface`.
- `grant_valid` out 1: a transaction is locked.
- `grant_id` out GW: index of the locked port.

## Operation
- FSM states: IDLE, BUSY.
- IDLE: all `mem_*` outputs driven 0. If any `req_access` is set, the picker selects winner w; on the clock edge `grant_id <= w`, `grant_valid <= 1`, state -> BUSY. No request: stay IDLE.
- BUSY: `mem_access = 1`; `mem_write`, `mem_a`, `mem_size`, `mem_sel`, `mem_st_data` are combinationally muxed from port `grant_id`. `req_ready[grant_id] = mem_ready`; all other `req_ready` bits stay 0. On `mem_ready`, state -> IDLE, `grant_valid <= 0`, and the round-robin pointer updates to `grant_id` (RR build only).
- Grant is never preempted. If the granted port drops `req_access` mid-transaction because of a flush, BUSY holds until `mem_ready`, and `req_ready` still pulses. AXI transactions cannot be aborted.
- Requests from non-granted ports are ignored until the next IDLE cycle, with no queueing beyond the port's own held request.
- `mem_ready` while IDLE is ignored; no `req_ready` is raised.

## Timing
- Reset (async assert): state IDLE, every output 0, `grant_id` 0, RR pointer NUM_PORTS-1 so port 0 wins first.
- Arbitration latency: 1 cycle from `req_access` high in IDLE to `mem_access` high.
- Completion: `req_ready` is combinational with `mem_ready` in the same cycle.
- Back-to-back: at least one IDLE cycle, with `mem_access` low, between transactions. This guarantees `axi_interface` sees a deassert.
- Reset asserted mid-BUSY: immediate IDLE, `mem_access` drops asynchronously, and the transaction is lost.

## Configuration
- `MEM_ARB_RR_EN` defined: round-robin. The winner is the first requesting index strictly after the pointer, wrapping modulo NUM_PORTS.
- Not defined: fixed priority, lowest index wins. Port 0 = I-cache, matching the current I-over-D priority. The pointer is not implemented.

## Structure
- Package `mem_arb_pkg`: state enum (IDLE, BUSY), size constants `MEM_SIZE_BYTE/HALF/WORD`, `MEM_ARB_MAX_PORTS = 8`.
- One sub-module: `arb_pick`, a combinational picker (request vector, pointer -> winner index, any). It does the rotate/mask priority encode in RR mode and a plain priority encode otherwise.
- The top of the block holds the FSM, grant register, pointer and output muxes.

## Test plan
- Single request: port 1 load, `req_a` = 0x1FC0_0000, `mem_ready` after 5 cycles. Expect `mem_access` 1 cycle after request with `mem_a` = 0x1FC0_0000 and `mem_write` 0; `req_ready` = 0b10 for one cycle; then IDLE.
- Simultaneous ports 0 and 1, held continuously, NUM_PORTS=2:
  - RR build: grants 0,1,0,1.
  - Fixed build: grants 0,0,0.
  - Both builds: each grant separated by one `mem_access`-low cycle.
- Store passthrough: port 1 write, `req_sel` = 0b0011, `req_st_data` = 0xDEAD_BEEF. Expect identical values on `mem_sel`/`mem_st_data` and `mem_write` 1 throughout BUSY.
- Flush mid-transaction: granted port drops `req_access` in BUSY. `mem_access` stays 1 until `mem_ready`, and `req_ready` still pulses; the other port is granted afterwards.
- NUM_PORTS=4 RR with ports 1 and 3 requesting after reset: grants 1,3,1. A stray `mem_ready` while IDLE produces no `req_ready`.
- Reset mid-BUSY: `aresetn` low for 1 cycle. All outputs 0 immediately; the next request is granted to port 0 first.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory-port arbiter.
//   arb_state_t        : arbiter FSM state (IDLE, BUSY)
//   MEM_SIZE_*         : access size encodings carried on req_size / mem_size
//   MEM_ARB_MAX_PORTS  : upper bound on NUM_PORTS
package mem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
    localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
    localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

    localparam int MEM_ARB_MAX_PORTS = 8;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner picker for mem_port_arbiter.
// Build option: MEM_ARB_RR_EN selects round-robin (first requester strictly
// after ptr, wrapping); otherwise fixed priority with the lowest index winning,
// and the ptr port does not exist.
// Ports:
//   req    in  NUM_PORTS : request vector
//   ptr    in  GW        : index of the last granted port (round-robin only)
//   winner out GW        : selected index (0 when nothing requests)
//   any    out 1         : at least one request is present
module arb_pick
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int GW        = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
`ifdef MEM_ARB_RR_EN
    input  logic [GW-1:0]        ptr,
`endif
    output logic [GW-1:0]        winner,
    output logic                 any
);

    always_comb begin
        winner = '0;
        any    = |req;
`ifdef MEM_ARB_RR_EN
        // Walk from the farthest offset back to ptr+1 so the nearest
        // requester after the pointer is the last (and final) assignment.
        for (int k = NUM_PORTS; k >= 1; k--) begin
            if (req[(int'(ptr) + k) % NUM_PORTS]) begin
                winner = GW'((int'(ptr) + k) % NUM_PORTS);
            end
        end
`else
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (req[i]) begin
                winner = GW'(i);
            end
        end
`endif
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// N-port arbiter in front of the single axi_interface cache port. One grant
// is locked per transaction and is never preempted; the granted port's
// address/control/store data are steered to mem_* and mem_ready is returned
// only to that port as req_ready.
// Build option: MEM_ARB_RR_EN enables round-robin arbitration (pointer
// register present); default build is fixed priority, port 0 highest.
// Ports:
//   aclk, aresetn          : clock, asynchronous active-low reset
//   req_access/req_write   : per-port request and store flag
//   req_a/size/sel/st_data : per-port packed address, size, strobes, data
//   req_ready              : one-hot completion to the granted port
//   mem_access ... mem_st_data : request to axi_interface
//   mem_ready              : completion from axi_interface
//   grant_valid, grant_id  : locked grant status
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int GW        = $clog2(NUM_PORTS)
) (
    input  logic                           aclk,
    input  logic                           aresetn,
    input  logic [NUM_PORTS-1:0]           req_access,
    input  logic [NUM_PORTS-1:0]           req_write,
    input  logic [NUM_PORTS*ADDR_W-1:0]    req_a,
    input  logic [NUM_PORTS*2-1:0]         req_size,
    input  logic [NUM_PORTS*DATA_W/8-1:0]  req_sel,
    input  logic [NUM_PORTS*DATA_W-1:0]    req_st_data,
    output logic [NUM_PORTS-1:0]           req_ready,
    output logic                           mem_access,
    output logic                           mem_write,
    output logic [ADDR_W-1:0]              mem_a,
    output logic [1:0]                     mem_size,
    output logic [DATA_W/8-1:0]            mem_sel,
    output logic [DATA_W-1:0]              mem_st_data,
    input  logic                           mem_ready,
    output logic                           grant_valid,
    output logic [GW-1:0]                  grant_id
);

    localparam int SEL_W = DATA_W / 8;

    if (NUM_PORTS < 2 || NUM_PORTS > MEM_ARB_MAX_PORTS) begin : g_bad_ports
        $error("mem_port_arbiter: NUM_PORTS must be 2..%0d", MEM_ARB_MAX_PORTS);
    end

    arb_state_t    state;
    logic [GW-1:0] winner;
    logic          any;

`ifdef MEM_ARB_RR_EN
    logic [GW-1:0] rr_ptr;
`endif

    arb_pick #(
        .NUM_PORTS (NUM_PORTS),
        .GW        (GW)
    ) u_pick (
        .req    (req_access),
`ifdef MEM_ARB_RR_EN
        .ptr    (rr_ptr),
`endif
        .winner (winner),
        .any    (any)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= IDLE;
            grant_valid <= 1'b0;
            grant_id    <= '0;
`ifdef MEM_ARB_RR_EN
            // Pointer at the last port so port 0 is first after reset.
            rr_ptr      <= GW'(NUM_PORTS - 1);
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (any) begin
                        state       <= BUSY;
                        grant_valid <= 1'b1;
                        grant_id    <= winner;
                    end
                end
                BUSY: begin
                    // Held until completion even if the requester drops
                    // req_access: an AXI transaction cannot be aborted.
                    if (mem_ready) begin
                        state       <= IDLE;
                        grant_valid <= 1'b0;
`ifdef MEM_ARB_RR_EN
                        rr_ptr      <= grant_id;
`endif
                    end
                end
                default: begin
                    state       <= IDLE;
                    grant_valid <= 1'b0;
                end
            endcase
        end
    end

    // Output steering from the locked grant; everything is 0 in IDLE so the
    // AXI side always sees mem_access low for at least one cycle between
    // transactions.
    always_comb begin
        mem_access  = 1'b0;
        mem_write   = 1'b0;
        mem_a       = '0;
        mem_size    = '0;
        mem_sel     = '0;
        mem_st_data = '0;
        req_ready   = '0;
        if (state == BUSY) begin
            mem_access  = 1'b1;
            mem_write   = req_write[grant_id];
            mem_a       = req_a[int'(grant_id)*ADDR_W +: ADDR_W];
            mem_size    = req_size[int'(grant_id)*2 +: 2];
            mem_sel     = req_sel[int'(grant_id)*SEL_W +: SEL_W];
            mem_st_data = req_st_data[int'(grant_id)*DATA_W +: DATA_W];
            req_ready[grant_id] = mem_ready;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (NUM_PORTS=4). A transaction-level
// reference model tracks busy/grant/last-winner; directed scenarios check grant
// orders from a log of observed grants, then a randomized phase runs against
// the model. Expectations follow MEM_ARB_RR_EN if the build defines it.
module tb_mem_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int GW = $clog2(N);

    logic              aclk = 1'b0;
    logic              aresetn;
    logic [N-1:0]      req_access;
    logic [N-1:0]      req_write;
    logic [N*AW-1:0]   req_a;
    logic [N*2-1:0]    req_size;
    logic [N*SW-1:0]   req_sel;
    logic [N*DW-1:0]   req_st_data;
    logic [N-1:0]      req_ready;
    logic              mem_access;
    logic              mem_write;
    logic [AW-1:0]     mem_a;
    logic [1:0]        mem_size;
    logic [SW-1:0]     mem_sel;
    logic [DW-1:0]     mem_st_data;
    logic              mem_ready;
    logic              grant_valid;
    logic [GW-1:0]     grant_id;

    always #5 aclk = ~aclk;

    mem_port_arbiter #(
        .NUM_PORTS (N),
        .ADDR_W    (AW),
        .DATA_W    (DW)
    ) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .req_access  (req_access),
        .req_write   (req_write),
        .req_a       (req_a),
        .req_size    (req_size),
        .req_sel     (req_sel),
        .req_st_data (req_st_data),
        .req_ready   (req_ready),
        .mem_access  (mem_access),
        .mem_write   (mem_write),
        .mem_a       (mem_a),
        .mem_size    (mem_size),
        .mem_sel     (mem_sel),
        .mem_st_data (mem_st_data),
        .mem_ready   (mem_ready),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_val(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: transaction-level view of the arbiter.
    bit  m_busy;
    int  m_gid;
    int  m_last;
    int  bcnt;
    int  glog[$];
    int  expq[$];
    bit  prev_access;

    logic [N-1:0]  snap_ready;
    logic          snap_access;
    logic          snap_write;
    logic [AW-1:0] snap_a;
    logic [SW-1:0] snap_sel;
    logic [DW-1:0] snap_data;

    function automatic int pick(logic [N-1:0] r);
`ifdef MEM_ARB_RR_EN
        for (int k = 1; k <= N; k++) begin
            if (r[(m_last + k) % N]) return (m_last + k) % N;
        end
`else
        for (int i = 0; i < N; i++) begin
            if (r[i]) return i;
        end
`endif
        return -1;
    endfunction

    // Called just after a falling edge with this cycle's inputs applied.
    task automatic cycle();
        logic [N-1:0] exp_ready;
        int w;
        #1;
        if (!aresetn) begin
            m_busy = 1'b0;
            m_gid  = 0;
            m_last = N - 1;
        end
        exp_ready = '0;
        if (m_busy && mem_ready) exp_ready[m_gid] = 1'b1;
        check_val("mem_access",  64'(mem_access),  64'(m_busy));
        check_val("grant_valid", 64'(grant_valid), 64'(m_busy));
        check_val("grant_id",    64'(grant_id),    64'(m_gid));
        check_val("mem_write",   64'(mem_write),   m_busy ? 64'(req_write[m_gid]) : 64'd0);
        check_val("mem_a",       64'(mem_a),       m_busy ? 64'(req_a[m_gid*AW +: AW]) : 64'd0);
        check_val("mem_size",    64'(mem_size),    m_busy ? 64'(req_size[m_gid*2 +: 2]) : 64'd0);
        check_val("mem_sel",     64'(mem_sel),     m_busy ? 64'(req_sel[m_gid*SW +: SW]) : 64'd0);
        check_val("mem_st_data", 64'(mem_st_data), m_busy ? 64'(req_st_data[m_gid*DW +: DW]) : 64'd0);
        check_val("req_ready",   64'(req_ready),   64'(exp_ready));

        snap_ready  = req_ready;
        snap_access = mem_access;
        snap_write  = mem_write;
        snap_a      = mem_a;
        snap_sel    = mem_sel;
        snap_data   = mem_st_data;
        if (mem_access && !prev_access) glog.push_back(int'(grant_id));
        prev_access = mem_access;

        if (aresetn) begin
            if (!m_busy) begin
                w = pick(req_access);
                if (w >= 0) begin
                    m_busy = 1'b1;
                    m_gid  = w;
                end
            end else if (mem_ready) begin
                m_busy = 1'b0;
                m_last = m_gid;
            end
        end
        @(negedge aclk);
    endtask

    task automatic set_port(int p, bit wr, logic [AW-1:0] a, logic [1:0] sz,
                            logic [SW-1:0] sel, logic [DW-1:0] d);
        req_write[p]             = wr;
        req_a[p*AW +: AW]        = a;
        req_size[p*2 +: 2]       = sz;
        req_sel[p*SW +: SW]      = sel;
        req_st_data[p*DW +: DW]  = d;
        req_access[p]            = 1'b1;
    endtask

    // mem_ready on the lat-th busy cycle of each transaction.
    task automatic drive_ready(int lat);
        if (m_busy) bcnt++;
        else        bcnt = 0;
        mem_ready = (bcnt >= lat);
    endtask

    task automatic do_reset();
        req_access  = '0;
        req_write   = '0;
        req_a       = '0;
        req_size    = '0;
        req_sel     = '0;
        req_st_data = '0;
        mem_ready   = 1'b0;
        aresetn     = 1'b0;
        cycle();
        cycle();
        aresetn = 1'b1;
        bcnt    = 0;
        glog.delete();
    endtask

    task automatic check_glog(string tag);
        check_val({tag, "_count"}, 64'(glog.size() >= expq.size()), 64'd1);
        for (int i = 0; i < expq.size() && i < glog.size(); i++) begin
            check_val(tag, 64'(glog[i]), 64'(expq[i]));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn = 1'b1;
        m_busy  = 1'b0;
        m_gid   = 0;
        m_last  = N - 1;
        bcnt    = 0;
        prev_access = 1'b0;
        #2;

        // Reset state and single load from port 1.
        do_reset();
        check_val("rst_access", 64'(snap_access), 64'd0);
        cycle();
        set_port(1, 1'b0, 32'h1FC0_0000, 2'b10, 4'hF, 32'h0);
        cycle();
        check_val("t1_no_access_same_cycle", 64'(snap_access), 64'd0);
        cycle();
        check_val("t1_access", 64'(snap_access), 64'd1);
        check_val("t1_addr",   64'(snap_a),      64'h1FC0_0000);
        check_val("t1_write",  64'(snap_write),  64'd0);
        for (int i = 0; i < 3; i++) cycle();
        mem_ready = 1'b1;
        cycle();
        check_val("t1_ready", 64'(snap_ready), 64'b0010);
        mem_ready     = 1'b0;
        req_access[1] = 1'b0;
        cycle();
        check_val("t1_idle_after", 64'(snap_access), 64'd0);
        check_val("t1_ready_once", 64'(snap_ready),  64'd0);

        // Ports 0 and 1 held continuously.
        do_reset();
        set_port(0, 1'b0, 32'h0000_1000, 2'b10, 4'hF, 32'h0);
        set_port(1, 1'b0, 32'h0000_2000, 2'b10, 4'hF, 32'h0);
        for (int i = 0; i < 20; i++) begin
            drive_ready(3);
            cycle();
        end
`ifdef MEM_ARB_RR_EN
        expq = '{0, 1, 0, 1};
`else
        expq = '{0, 0, 0, 0};
`endif
        check_glog("t2_grants");

        // Store passthrough from port 1.
        do_reset();
        set_port(1, 1'b1, 32'h8000_0010, 2'b10, 4'b0011, 32'hDEAD_BEEF);
        for (int i = 0; i < 8; i++) begin
            drive_ready(4);
            cycle();
            if (snap_access) begin
                check_val("t3_write", 64'(snap_write), 64'd1);
                check_val("t3_sel",   64'(snap_sel),   64'b0011);
                check_val("t3_data",  64'(snap_data),  64'hDEAD_BEEF);
            end
            if (snap_ready[1]) req_access[1] = 1'b0;
        end

        // Flush: granted port 0 drops its request while BUSY.
        begin
            bit saw0;
            saw0 = 1'b0;
            do_reset();
            set_port(0, 1'b0, 32'h0000_0040, 2'b10, 4'hF, 32'h0);
            set_port(1, 1'b1, 32'h0000_0080, 2'b01, 4'b1100, 32'h1234_5678);
            for (int i = 0; i < 14; i++) begin
                drive_ready(4);
                if (m_busy && m_gid == 0) req_access[0] = 1'b0;
                cycle();
                if (snap_ready[0]) saw0 = 1'b1;
                if (snap_ready[1]) req_access[1] = 1'b0;
            end
            check_val("t4_flush_ready_pulse", 64'(saw0), 64'd1);
            expq = '{0, 1};
            check_glog("t4_grants");
        end

        // Ports 1 and 3 requesting after reset, then a stray mem_ready.
        do_reset();
        set_port(1, 1'b0, 32'h0000_0100, 2'b00, 4'b0001, 32'h0);
        set_port(3, 1'b0, 32'h0000_0300, 2'b01, 4'b0011, 32'h0);
        for (int i = 0; i < 14; i++) begin
            drive_ready(2);
            cycle();
        end
`ifdef MEM_ARB_RR_EN
        expq = '{1, 3, 1};
`else
        expq = '{1, 1, 1};
`endif
        check_glog("t5_grants");
        req_access = '0;
        mem_ready  = 1'b1;
        cycle();
        mem_ready = 1'b0;
        cycle();
        mem_ready = 1'b1;
        cycle();
        check_val("t5_stray_ready",  64'(snap_ready),  64'd0);
        check_val("t5_stray_access", 64'(snap_access), 64'd0);
        mem_ready = 1'b0;

        // Reset mid-BUSY.
        do_reset();
        set_port(2, 1'b1, 32'h0000_0200, 2'b10, 4'hF, 32'hCAFE_F00D);
        cycle();
        cycle();
        check_val("t6_busy_before_rst", 64'(snap_access), 64'd1);
        aresetn = 1'b0;
        cycle();
        check_val("t6_access_in_rst", 64'(snap_access), 64'd0);
        aresetn    = 1'b1;
        req_access = '0;
        glog.delete();
        set_port(0, 1'b0, 32'h0000_0004, 2'b10, 4'hF, 32'h0);
        set_port(2, 1'b0, 32'h0000_0008, 2'b10, 4'hF, 32'h0);
        bcnt = 0;
        for (int i = 0; i < 6; i++) begin
            drive_ready(2);
            cycle();
        end
        expq = '{0};
        check_glog("t6_first_grant");

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            for (int p = 0; p < N; p++) begin
                if (req_access[p]) begin
                    if (snap_ready[p]) begin
                        if ($urandom_range(1, 0) == 0) req_access[p] = 1'b0;
                        else set_port(p, 1'($urandom_range(1, 0)), AW'($urandom),
                                      2'($urandom_range(2, 0)), SW'($urandom), DW'($urandom));
                    end else if (m_busy && m_gid == p && $urandom_range(15, 0) == 0) begin
                        req_access[p] = 1'b0;
                    end
                end else if ($urandom_range(2, 0) == 0) begin
                    set_port(p, 1'($urandom_range(1, 0)), AW'($urandom),
                             2'($urandom_range(2, 0)), SW'($urandom), DW'($urandom));
                end
            end
            mem_ready = ($urandom_range(3, 0) == 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
